// File: rtl/iomem_master_arb_pkg.sv
// Shared cpu-side iomem bus types.
// Line width, client ids, FSM states and request bundle.
package iomem_master_arb_pkg;

  localparam int BLOCK_SIZE = 128;
  localparam int NUMS_BYTE  = BLOCK_SIZE / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    CLI_IC = 1'b0,
    CLI_DC = 1'b1
  } cli_e;

  typedef struct packed {
    logic [31:0]           addr;
    logic [NUMS_BYTE-1:0]  wstrb;
    logic [BLOCK_SIZE-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/iomem_master_arb_rr_arbiter.sv
// Two-way round-robin grant between icache and dcache.
// Pointer names the preferred client; it flips on every taken grant.
module iomem_rr_arbiter
  import iomem_master_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ic_req_i,
  input  logic dc_req_i,
  input  logic en_i,
  output logic gnt_o,
  output cli_e gnt_id_o
);

  cli_e ptr_q;
  cli_e ptr_d;
  cli_e gnt_id;

  // Pick a winner; pointer breaks ties.
  always_comb begin
    gnt_id = CLI_IC;
    unique case (1'b1)
      ic_req_i && dc_req_i:  gnt_id = ptr_q;
      dc_req_i && !ic_req_i: gnt_id = CLI_DC;
      default:               gnt_id = CLI_IC;
    endcase
  end

  assign gnt_o    = ic_req_i | dc_req_i;
  assign gnt_id_o = gnt_id;

  // Prefer the other client after any grant.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i && gnt_o) begin
      ptr_d = (gnt_id == CLI_IC) ? CLI_DC : CLI_IC;
    end
  end

  // Pointer register, dc preferred out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= CLI_DC;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/iomem_master_arb.sv
// iomem block-bus initiator for icache fills and dcache fill/writeback.
// Registered bus outputs, one-cycle acks, round-robin and bus timeout.
module iomem_master_arb
  import iomem_master_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ic_req_i,
  input  logic [31:0]           ic_addr_i,
  output logic                  ic_ack_o,
  output logic                  ic_err_o,
  output logic [BLOCK_SIZE-1:0] ic_rdata_o,
  input  logic                  dc_req_i,
  input  logic [31:0]           dc_addr_i,
  input  logic [NUMS_BYTE-1:0]  dc_wstrb_i,
  input  logic [BLOCK_SIZE-1:0] dc_wdata_i,
  output logic                  dc_ack_o,
  output logic                  dc_err_o,
  output logic [BLOCK_SIZE-1:0] dc_rdata_o,
  output logic                  iomem_valid,
  input  logic                  iomem_ready,
  output logic [NUMS_BYTE-1:0]  iomem_wstrb,
  output logic [31:0]           iomem_addr,
  output logic [BLOCK_SIZE-1:0] iomem_wdata,
  input  logic [BLOCK_SIZE-1:0] iomem_rdata
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_e                state_q, state_d;
  cli_e                  gnt_q, gnt_d;
  bus_req_t              req_q, req_d;
  logic                  valid_q, valid_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic                  ic_ack_q, ic_ack_d;
  logic                  ic_err_q, ic_err_d;
  logic [BLOCK_SIZE-1:0] ic_rdata_q, ic_rdata_d;
  logic                  dc_ack_q, dc_ack_d;
  logic                  dc_err_q, dc_err_d;
  logic [BLOCK_SIZE-1:0] dc_rdata_q, dc_rdata_d;

  logic arb_en;
  logic arb_gnt;
  cli_e arb_id;

  assign arb_en = (state_q == ST_IDLE);

  iomem_rr_arbiter u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .ic_req_i (ic_req_i),
    .dc_req_i (dc_req_i),
    .en_i     (arb_en),
    .gnt_o    (arb_gnt),
    .gnt_id_o (arb_id)
  );

  // Grant, hold the bus until ready or timeout, then pulse the ack.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    req_d      = req_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    cnt_inc    = cnt_q + CW'(1);
    ic_ack_d   = 1'b0;
    ic_err_d   = 1'b0;
    ic_rdata_d = ic_rdata_q;
    dc_ack_d   = 1'b0;
    dc_err_d   = 1'b0;
    dc_rdata_d = dc_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_gnt) begin
          gnt_d   = arb_id;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_REQ;
          if (arb_id == CLI_DC) begin
            req_d.addr  = dc_addr_i;
            req_d.wstrb = dc_wstrb_i;
            req_d.wdata = dc_wdata_i;
          end else begin
            req_d.addr  = ic_addr_i;
            req_d.wstrb = '0;
            req_d.wdata = '0;
          end
        end
      end
      ST_REQ: begin
        if (iomem_ready) begin
          valid_d = 1'b0;
          state_d = ST_RESP;
          if (gnt_q == CLI_DC) begin
            dc_ack_d   = 1'b1;
            dc_rdata_d = iomem_rdata;
          end else begin
            ic_ack_d   = 1'b1;
            ic_rdata_d = iomem_rdata;
          end
        end else if (TO_EN && (cnt_inc == TO_CNT)) begin
          valid_d = 1'b0;
          state_d = ST_RESP;
          if (gnt_q == CLI_DC) begin
            dc_ack_d   = 1'b1;
            dc_err_d   = 1'b1;
            dc_rdata_d = '0;
          end else begin
            ic_ack_d   = 1'b1;
            ic_err_d   = 1'b1;
            ic_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      gnt_q      <= CLI_IC;
      req_q      <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      ic_ack_q   <= 1'b0;
      ic_err_q   <= 1'b0;
      ic_rdata_q <= '0;
      dc_ack_q   <= 1'b0;
      dc_err_q   <= 1'b0;
      dc_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      ic_ack_q   <= ic_ack_d;
      ic_err_q   <= ic_err_d;
      ic_rdata_q <= ic_rdata_d;
      dc_ack_q   <= dc_ack_d;
      dc_err_q   <= dc_err_d;
      dc_rdata_q <= dc_rdata_d;
    end
  end

  assign iomem_valid = valid_q;
  assign iomem_addr  = req_q.addr;
  assign iomem_wstrb = req_q.wstrb;
  assign iomem_wdata = req_q.wdata;
  assign ic_ack_o    = ic_ack_q;
  assign ic_err_o    = ic_err_q;
  assign ic_rdata_o  = ic_rdata_q;
  assign dc_ack_o    = dc_ack_q;
  assign dc_err_o    = dc_err_q;
  assign dc_rdata_o  = dc_rdata_q;

endmodule

// File: tb/tb_iomem_master_arb.sv
// Directed bench for iomem_master_arb.
// Vector table plus hand sequences for reset and corner cases.
module tb_iomem_master_arb;
  import iomem_master_arb_pkg::*;

  typedef struct {
    logic         ic_req;
    logic         dc_req;
    logic [31:0]  ic_addr;
    logic [31:0]  dc_addr;
    logic [15:0]  wstrb;
    logic [127:0] wdata;
    logic [127:0] line;
    int           lat;
    logic         drop;
    logic         exp_dc;
    logic [31:0]  exp_addr;
    logic [15:0]  exp_wstrb;
    logic [127:0] exp_wdata;
    int           exp_vcyc;
    logic         exp_err;
    logic [127:0] exp_rdata;
  } vec_t;

  localparam logic [127:0] W1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] WB = 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF;
  localparam logic [127:0] L1 = 128'hA1A1_0001_A1A1_0002_A1A1_0003_A1A1_0004;
  localparam logic [127:0] L2 = 128'hB2B2_0001_B2B2_0002_B2B2_0003_B2B2_0004;
  localparam logic [127:0] L3 = 128'hC3C3_0001_C3C3_0002_C3C3_0003_C3C3_0004;
  localparam logic [127:0] L4 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] L5 = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
  localparam logic [127:0] L6 = 128'h6666_0000_6666_1111_6666_2222_6666_3333;
  localparam logic [127:0] L7 = 128'h7777_7777_0000_0000_7777_7777_0000_0001;
  localparam logic [127:0] L8 = 128'h8888_1234_8888_5678_8888_9ABC_8888_DEF0;
  localparam logic [127:0] L9 = 128'h9999_0000_9999_0000_9999_0000_9999_FFFF;

  logic         clk_i;
  logic         rst_ni;
  logic         ic_req_i;
  logic [31:0]  ic_addr_i;
  logic         ic_ack_o;
  logic         ic_err_o;
  logic [127:0] ic_rdata_o;
  logic         dc_req_i;
  logic [31:0]  dc_addr_i;
  logic [15:0]  dc_wstrb_i;
  logic [127:0] dc_wdata_i;
  logic         dc_ack_o;
  logic         dc_err_o;
  logic [127:0] dc_rdata_o;
  logic         iomem_valid;
  logic         iomem_ready;
  logic [15:0]  iomem_wstrb;
  logic [31:0]  iomem_addr;
  logic [127:0] iomem_wdata;
  logic [127:0] iomem_rdata;

  int checks;
  int errors;
  int lat;
  int wait_cnt;
  logic [127:0] last_ic;
  logic [127:0] last_dc;
  vec_t vecs [9];

  iomem_master_arb dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ic_req_i    (ic_req_i),
    .ic_addr_i   (ic_addr_i),
    .ic_ack_o    (ic_ack_o),
    .ic_err_o    (ic_err_o),
    .ic_rdata_o  (ic_rdata_o),
    .dc_req_i    (dc_req_i),
    .dc_addr_i   (dc_addr_i),
    .dc_wstrb_i  (dc_wstrb_i),
    .dc_wdata_i  (dc_wdata_i),
    .dc_ack_o    (dc_ack_o),
    .dc_err_o    (dc_err_o),
    .dc_rdata_o  (dc_rdata_o),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Responder: ready after valid has been up for lat cycles.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)           wait_cnt <= 0;
    else if (!iomem_valid) wait_cnt <= 0;
    else                   wait_cnt <= wait_cnt + 1;
  end
  assign iomem_ready = iomem_valid && (wait_cnt >= lat);

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic icr, input logic dcr,
    input logic [31:0] ica, input logic [31:0] dca,
    input logic [15:0] ws, input logic [127:0] wd,
    input logic [127:0] ln, input int lt, input logic dr,
    input logic edc, input logic [31:0] ea,
    input logic [15:0] ews, input logic [127:0] ewd,
    input int ev, input logic eerr, input logic [127:0] erd);
    vec_t v;
    v.ic_req = icr;   v.dc_req = dcr;
    v.ic_addr = ica;  v.dc_addr = dca;
    v.wstrb = ws;     v.wdata = wd;
    v.line = ln;      v.lat = lt;  v.drop = dr;
    v.exp_dc = edc;   v.exp_addr = ea;
    v.exp_wstrb = ews; v.exp_wdata = ewd;
    v.exp_vcyc = ev;  v.exp_err = eerr;
    v.exp_rdata = erd;
    return v;
  endfunction

  // Entered at a negedge with the FSM idle; leaves at a negedge.
  task automatic do_vec(input vec_t v, input string tag);
    int vcnt;
    int n;
    logic done;
    logic bad_bus;
    logic bad_ack;
    vcnt = 0; n = 0; done = 1'b0;
    bad_bus = 1'b0; bad_ack = 1'b0;
    lat         = v.lat;
    iomem_rdata = v.line;
    ic_req_i    = v.ic_req;
    dc_req_i    = v.dc_req;
    ic_addr_i   = v.ic_addr;
    dc_addr_i   = v.dc_addr;
    dc_wstrb_i  = v.wstrb;
    dc_wdata_i  = v.wdata;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk_i);
      n++;
      if (iomem_valid) begin
        if (vcnt == 0) begin
          chk({tag, ".addr"}, iomem_addr, v.exp_addr);
          chk({tag, ".wstrb"}, iomem_wstrb, v.exp_wstrb);
          chk({tag, ".wdata"}, iomem_wdata, v.exp_wdata);
        end else if (iomem_addr !== v.exp_addr ||
                     iomem_wstrb !== v.exp_wstrb ||
                     iomem_wdata !== v.exp_wdata) begin
          bad_bus = 1'b1;
        end
        if (ic_ack_o || dc_ack_o) bad_ack = 1'b1;
        vcnt++;
        if (v.drop) begin
          ic_req_i = 1'b0;
          dc_req_i = 1'b0;
        end
      end else if (vcnt > 0) begin
        done = 1'b1;
      end
    end
    chk({tag, ".completed"}, done, 1'b1);
    chk({tag, ".valid_cycles"}, vcnt, v.exp_vcyc);
    chk({tag, ".ack_latency"}, n, v.exp_vcyc + 1);
    chk({tag, ".bus_stable"}, bad_bus, 1'b0);
    chk({tag, ".early_ack"}, bad_ack, 1'b0);
    if (v.exp_dc) begin
      chk({tag, ".dc_ack"}, dc_ack_o, 1'b1);
      chk({tag, ".dc_err"}, dc_err_o, v.exp_err);
      chk({tag, ".dc_rdata"}, dc_rdata_o, v.exp_rdata);
      chk({tag, ".ic_ack"}, ic_ack_o, 1'b0);
      chk({tag, ".ic_rdata_hold"}, ic_rdata_o, last_ic);
      last_dc = v.exp_rdata;
    end else begin
      chk({tag, ".ic_ack"}, ic_ack_o, 1'b1);
      chk({tag, ".ic_err"}, ic_err_o, v.exp_err);
      chk({tag, ".ic_rdata"}, ic_rdata_o, v.exp_rdata);
      chk({tag, ".dc_ack"}, dc_ack_o, 1'b0);
      chk({tag, ".dc_rdata_hold"}, dc_rdata_o, last_dc);
      last_ic = v.exp_rdata;
    end
    ic_req_i = 1'b0;
    dc_req_i = 1'b0;
    @(negedge clk_i);
    chk({tag, ".ack_pulse"}, {ic_ack_o, dc_ack_o}, 2'b00);
    chk({tag, ".gap_valid"}, iomem_valid, 1'b0);
  endtask

  initial begin
    vec_t fresh;
    checks = 0; errors = 0; lat = 0;
    last_ic = '0; last_dc = '0;
    rst_ni = 1'b0;
    ic_req_i = 1'b0; dc_req_i = 1'b0;
    ic_addr_i = '0; dc_addr_i = '0;
    dc_wstrb_i = '0; dc_wdata_i = '0;
    iomem_rdata = '0;

    // Both requesting from reset: dc, ic, dc.
    vecs[0] = mk(1, 1, 32'h1000_0000, 32'h2000_0000, 16'hFFFF, W1, L1, 1, 0,
                 1, 32'h2000_0000, 16'hFFFF, W1, 2, 0, L1);
    vecs[1] = mk(1, 1, 32'h1000_0000, 32'h2000_0000, 16'hFFFF, W1, L2, 1, 0,
                 0, 32'h1000_0000, 16'h0000, '0, 2, 0, L2);
    vecs[2] = mk(1, 1, 32'h1000_0000, 32'h2000_0000, 16'hFFFF, W1, L3, 1, 0,
                 1, 32'h2000_0000, 16'hFFFF, W1, 2, 0, L3);
    vecs[3] = mk(1, 0, 32'h4000_0040, 32'h0, 16'h0, '0, L4, 15, 0,
                 0, 32'h4000_0040, 16'h0000, '0, 16, 0, L4);
    vecs[4] = mk(0, 1, 32'h0, 32'h4000_0100, 16'h000F, WB, L5, 3, 0,
                 1, 32'h4000_0100, 16'h000F, WB, 4, 0, L5);
    vecs[5] = mk(0, 1, 32'h0, 32'h3000_0004, 16'h0, '0, L6, 0, 0,
                 1, 32'h3000_0004, 16'h0000, '0, 1, 0, L6);
    vecs[6] = mk(0, 1, 32'h0, 32'h5000_0000, 16'h0, '0, L7, 1000, 0,
                 1, 32'h5000_0000, 16'h0000, '0, 64, 1, '0);
    vecs[7] = mk(0, 1, 32'h0, 32'h5000_0010, 16'h0, '0, L7, 63, 0,
                 1, 32'h5000_0010, 16'h0000, '0, 64, 0, L7);
    vecs[8] = mk(1, 0, 32'h4000_0080, 32'h0, 16'h0, '0, L8, 5, 1,
                 0, 32'h4000_0080, 16'h0000, '0, 6, 0, L8);

    repeat (2) @(negedge clk_i);
    chk("rst.valid", iomem_valid, 1'b0);
    chk("rst.addr", iomem_addr, 32'h0);
    chk("rst.wstrb", iomem_wstrb, 16'h0);
    chk("rst.wdata", iomem_wdata, '0);
    chk("rst.acks", {ic_ack_o, dc_ack_o, ic_err_o, dc_err_o}, 4'h0);
    chk("rst.ic_rdata", ic_rdata_o, '0);
    chk("rst.dc_rdata", dc_rdata_o, '0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 9; i++) begin
      do_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted while a request is outstanding.
    lat = 1000;
    dc_req_i = 1'b1;
    dc_addr_i = 32'h5000_0020;
    dc_wstrb_i = '0;
    repeat (4) @(negedge clk_i);
    chk("midrst.valid_before", iomem_valid, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst.valid_async", iomem_valid, 1'b0);
    chk("midrst.addr_async", iomem_addr, 32'h0);
    @(negedge clk_i);
    dc_req_i = 1'b0;
    chk("midrst.no_ack", {ic_ack_o, dc_ack_o}, 2'b00);
    last_ic = '0;
    last_dc = '0;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("midrst.idle_after", iomem_valid, 1'b0);
    fresh = mk(0, 1, 32'h0, 32'h6000_0020, 16'h0, '0, L9, 2, 0,
               1, 32'h6000_0020, 16'h0000, '0, 3, 0, L9);
    do_vec(fresh, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iomem_master_arb.md
Name: iomem_master_arb

Overview:
- Initiator end of the 128-bit iomem block bus, inside the cpu.
- Arbitrates between the instruction-cache line fill client (ic, read-only) and the data-cache fill/writeback client (dc, read/write).
- Drives iomem_valid/addr/wstrb/wdata and holds them stable until the responder asserts iomem_ready, then returns read data to the granted client.
- Provides round-robin fairness and a bus timeout so a missing responder cannot hang the core.

Parameters:
- BLOCK_SIZE, 128, bus data width in bits.
- NUMS_BYTE, BLOCK_SIZE/8, strobe width.
- TIMEOUT_CYCLES, 64, cycles in REQ without iomem_ready before error completion. 0 disables the timeout.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- ic_req_i  in  1  icache request; held until ic_ack_o.
- ic_addr_i  in  32  icache request address.
- ic_ack_o  out  1  one-cycle completion pulse.
- ic_err_o  out  1  valid with ic_ack_o; 1 = timeout.
- ic_rdata_o  out  BLOCK_SIZE  read line; valid with ic_ack_o.
- dc_req_i  in  1  dcache request; held until dc_ack_o.
- dc_addr_i  in  32  dcache request address.
- dc_wstrb_i  in  NUMS_BYTE  byte strobes; 0 = read.
- dc_wdata_i  in  BLOCK_SIZE  write data.
- dc_ack_o  out  1  one-cycle completion pulse.
- dc_err_o  out  1  valid with dc_ack_o; 1 = timeout.
- dc_rdata_o  out  BLOCK_SIZE  read line; valid with dc_ack_o.
- iomem_valid  out  1  bus request valid.
- iomem_ready  in  1  responder completion; may be combinational from iomem_valid.
- iomem_wstrb  out  NUMS_BYTE  byte strobes; all-zero for ic.
- iomem_addr  out  32  request address, passed unmodified (low bits are not masked; word-exact I/O addresses must survive).
- iomem_wdata  out  BLOCK_SIZE  write data.
- iomem_rdata  in  BLOCK_SIZE  read data; sampled when iomem_valid & iomem_ready.

Behaviour:
- All outputs are registered.
- Reset values: iomem_valid=0; iomem_addr, iomem_wstrb, iomem_wdata = 0; acks=0; errs=0; rdata outputs=0; state=IDLE; rr pointer = dc-preferred; timeout counter=0.
- Asynchronous reset mid-transaction: iomem_valid drops immediately; no ack is issued; the client re-requests after reset.
- States: IDLE, REQ, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One requester: grant it.
  - Both requesting: grant the client not served last (rr pointer). The pointer updates on every grant.
  - On grant: latch addr/wstrb/wdata (ic: wstrb=0, wdata=0) and the grant id; next state REQ.
  - Latency: req seen at edge N → iomem_valid=1 after edge N.
- REQ:
  - iomem_valid=1; bus outputs stable; counter increments each cycle.
  - On iomem_ready=1 at an edge: capture iomem_rdata into the granted client's rdata register; assert its ack (err=0); clear iomem_valid; go to RESP.
  - A zero-wait responder (ready in the first REQ cycle) gives 1 REQ cycle, so req→ack is 2 cycles.
  - Timeout (TIMEOUT_CYCLES≠0): if the counter reaches TIMEOUT_CYCLES with ready still 0, drop valid, ack with err=1 and rdata=0, go to RESP. Ready arriving on the same edge as expiry wins: normal completion, err=0.
- RESP:
  - Exactly one cycle; ack=1 for the granted client only; iomem_valid=0.
  - Requests are ignored in this cycle; the client must deassert req here or it is re-granted from IDLE.
  - Next state IDLE. Minimum gap of 1 idle-bus cycle between transactions, so the responder always sees valid low between requests.
- A client dropping req while in REQ: the transaction still completes and ack is still pulsed.
- rdata outputs hold their last value between acks.
- Non-granted client's ack and err stay 0 throughout.
- Counter width: $clog2(TIMEOUT_CYCLES+1); no wrap, because the counter clears on entry to REQ.

Decomposition:
- Shared cpu package holds:
  - BLOCK_SIZE and NUMS_BYTE constants.
  - State enum (IDLE/REQ/RESP).
  - Client id typedef (CLI_IC, CLI_DC).
  - Bus request struct {addr, wstrb, wdata}.
- One natural sub-module: iomem_rr_arbiter, a 2-way round-robin grant with pointer update. The FSM, latching and timeout stay in the top.

Test Plan:
- ic read, 16-cycle-latency responder, addr 0x4000_0040 → iomem_addr=0x4000_0040 and wstrb=0 held for 16 cycles; ic_ack_o one cycle with rdata equal to the responder line; ic_err_o=0.
- dc write, addr 0x4000_0100, wstrb=0x000F, wdata=0x...DEADBEEF → bus carries the exact strobe and data; dc_ack_o pulses; ic_ack_o stays 0.
- ic and dc requesting in the same cycle, three back-to-back rounds → grants alternate dc, ic, dc (from reset); at least one idle valid=0 cycle between bus transactions.
- dc read of 0x3000_0004, responder ready combinationally → iomem_addr unmasked 0x3000_0004; dc_ack_o 2 cycles after req.
- No responder, TIMEOUT_CYCLES=64 → valid high for exactly 64 cycles, then dc_ack_o=1, dc_err_o=1, dc_rdata_o=0; ready arriving on cycle 64 → err=0.
- rst_ni low mid-REQ → iomem_valid low immediately (asynchronous); no ack; after release, a fresh request completes normally.
